// File: rtl/steer_position_ctrl.sv
// steer_position_ctrl: sole owner of the 3-bit steering position code
module steer_position_ctrl #(
  parameter int TICK_DIV     = 250000,
  parameter int BTN_DB_TICKS = 3,
  parameter int IDLE_TICKS   = 300,
  parameter int STEP_TICKS   = 50,
  parameter int LOCK_TICKS   = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       knob_left,
  input  logic       knob_right,
  input  logic       btn,
  input  logic       rem_req,
  input  logic [1:0] rem_dir,
  output logic       rem_ack,
  output logic [2:0] pos,
  output logic       pos_chg,
  output logic       returning
);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int IW = $clog2(IDLE_TICKS + 1);
  localparam int SW = $clog2(STEP_TICKS + 1);
  localparam int LW = $clog2(LOCK_TICKS + 1);

  typedef enum logic {R_IDLE, R_WAIT} r_state_t;
  typedef enum logic {C_HOLD, C_RETURN} c_state_t;

  r_state_t                r_state_q;
  c_state_t                c_state_q;
  logic [TW-1:0]           tick_cnt_q;
  logic [BTN_DB_TICKS-1:0] hist_q, hist_d;
  logic [IW-1:0]           idle_q;
  logic [SW-1:0]           step_q;
  logic [LW-1:0]           lock_q;
  logic signed [2:0]       lvl_q, lvl_d, sat_r, sat_l, toward, rem_lvl;
  logic [1:0]              mag;
  logic                    rem_ack_q, pos_chg_q;
  logic                    tick, knob_act, btn_edge, rem_go, act, auto_step;

  always_comb begin
    tick      = tick_cnt_q == TW'(TICK_DIV - 1);
    hist_d    = (hist_q << 1) | BTN_DB_TICKS'(btn);
    btn_edge  = tick && (&hist_d) && !(&hist_q);
    knob_act  = knob_left | knob_right;
    rem_go    = r_state_q == R_IDLE && rem_req && lock_q == '0 && !knob_act && !btn_edge;
    act       = knob_act | btn_edge | rem_go;
    sat_r     = lvl_q == 3'sd3 ? lvl_q : lvl_q + 3'sd1;
    sat_l     = lvl_q == -3'sd3 ? lvl_q : lvl_q - 3'sd1;
    toward    = lvl_q[2] ? lvl_q + 3'sd1 : lvl_q - 3'sd1;
    rem_lvl   = rem_dir == 2'b01 ? sat_r :
                rem_dir == 2'b10 ? sat_l :
                rem_dir == 2'b11 ? 3'sd0 : lvl_q;
    auto_step = c_state_q == C_RETURN && tick && step_q == SW'(STEP_TICKS - 1) && !act;
    lvl_d     = btn_edge               ? 3'sd0 :
                knob_left ^ knob_right ? (knob_right ? sat_r : sat_l) :
                rem_go                 ? rem_lvl :
                auto_step              ? toward : lvl_q;
    mag       = lvl_q[2] ? 2'(-lvl_q) : lvl_q[1:0];
  end

  assign pos       = {lvl_q[2] | (lvl_q == 3'sd0), mag};
  assign rem_ack   = rem_ack_q;
  assign pos_chg   = pos_chg_q;
  assign returning = c_state_q == C_RETURN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q  <= R_IDLE;
      c_state_q  <= C_HOLD;
      tick_cnt_q <= '0;
      hist_q     <= '0;
      idle_q     <= '0;
      step_q     <= '0;
      lock_q     <= '0;
      lvl_q      <= 3'sd0;
      rem_ack_q  <= 1'b0;
      pos_chg_q  <= 1'b0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      if (tick)
        hist_q <= hist_d;
      lock_q     <= knob_act ? LW'(LOCK_TICKS) :
                    (tick && lock_q != '0) ? lock_q - 1'b1 : lock_q;
      lvl_q      <= lvl_d;
      pos_chg_q  <= lvl_d != lvl_q;
      rem_ack_q  <= rem_go;
      r_state_q  <= rem_go ? R_WAIT :
                    (r_state_q == R_WAIT && !rem_req) ? R_IDLE : r_state_q;
      case (c_state_q)
        C_HOLD: begin
          if (act)
            idle_q <= '0;
          else if (idle_q == IW'(IDLE_TICKS) && lvl_q != 3'sd0) begin
            c_state_q <= C_RETURN;
            step_q    <= '0;
          end else if (tick && idle_q != IW'(IDLE_TICKS))
            idle_q <= idle_q + 1'b1;
        end
        C_RETURN: begin
          if (act) begin
            c_state_q <= C_HOLD;
            idle_q    <= '0;
          end else if (tick) begin
            if (step_q == SW'(STEP_TICKS - 1)) begin
              step_q <= '0;
              if (toward == 3'sd0) begin
                c_state_q <= C_HOLD;
                idle_q    <= '0;
              end
            end else
              step_q <= step_q + 1'b1;
          end
        end
        default: c_state_q <= C_HOLD;
      endcase
    end
  end
endmodule
